dmac_mc_engine: RTL and testbench

//  NUM_CH-channel AXI3 DMA mover; next generation of the single-channel DMAC engine. Sits behind the APB config block.

---
 rtl/dmac_pkg.sv | 13 +
 rtl/dmac_rr_arbiter.sv | 27 ++
 rtl/dmac_mc_engine.sv | 175 +++++++++++++++++
 tb/tb_dmac_mc_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// dmac_pkg: shared engine FSM encodings and fixed AXI3 constants for the multi-channel DMA engine.
package dmac_pkg;
    localparam int ID_W = 4;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RREQ  = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WREQ  = 3'd3;
    localparam logic [2:0] ST_WDATA = 3'd4;
    localparam logic [2:0] ST_WAIT  = 3'd5;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/dmac_rr_arbiter.sv
// dmac_rr_arbiter: round-robin pick among pending channels, priority starting at last+1.
module dmac_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last,
    output logic [NUM_CH-1:0] gnt,
    output logic [CW-1:0]     idx
);
    int best, d;
    // Distance from last+1 (mod NUM_CH); the smallest distance among requesters wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        best = NUM_CH;
        d = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            d = (j + NUM_CH - 1 - int'(last)) % NUM_CH;
            if (req[j] && d < best) begin
                best = d;
                idx = CW'(j);
            end
        end
        if (best < NUM_CH) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/dmac_mc_engine.sv
// dmac_mc_engine: NUM_CH-channel AXI3 DMA mover, round-robin per burst, read->write->B strictly in order.
// Optional DMAC_ERR_EN: non-OKAY rresp/bresp sets sticky err_o and aborts the channel after its burst.
module dmac_mc_engine import dmac_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH*32-1:0]   src_addr_i,
    input  logic [NUM_CH*32-1:0]   dst_addr_i,
    input  logic [NUM_CH*16-1:0]   byte_len_i,
    input  logic [NUM_CH-1:0]      start_i,
    output logic [NUM_CH-1:0]      done_o,
    output logic [NUM_CH-1:0]      err_o,
    output logic                   awvalid_o,
    input  logic                   awready_i,
    output logic [31:0]            awaddr_o,
    output logic [3:0]             awlen_o,
    output logic [2:0]             awsize_o,
    output logic [1:0]             awburst_o,
    output logic [ID_W-1:0]        awid_o,
    output logic                   wvalid_o,
    input  logic                   wready_i,
    output logic [31:0]            wdata_o,
    output logic [3:0]             wstrb_o,
    output logic                   wlast_o,
    output logic [ID_W-1:0]        wid_o,
    input  logic                   bvalid_i,
    output logic                   bready_o,
    input  logic [1:0]             bresp_i,
    input  logic [ID_W-1:0]        bid_i,
    output logic                   arvalid_o,
    input  logic                   arready_i,
    output logic [31:0]            araddr_o,
    output logic [3:0]             arlen_o,
    output logic [2:0]             arsize_o,
    output logic [1:0]             arburst_o,
    output logic [ID_W-1:0]        arid_o,
    input  logic                   rvalid_i,
    output logic                   rready_o,
    input  logic [31:0]            rdata_i,
    input  logic [1:0]             rresp_i,
    input  logic                   rlast_i,
    input  logic [ID_W-1:0]        rid_i
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;

    logic [2:0]        state;
    logic [CW-1:0]     ch, last_grant, gnt_idx;
    logic [NUM_CH-1:0] gnt, acc;
    logic [4:0]        beats, cnt;
    logic [31:0]       src_q [NUM_CH];
    logic [31:0]       dst_q [NUM_CH];
    logic [15:0]       rem_q [NUM_CH];
    logic [31:0]       mem [2**BW];
    logic [13:0]       words;
    logic [15:0]       rem_n;
    logic              abort;

    dmac_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
        .req(~done_o), .last(last_grant), .gnt(gnt), .idx(gnt_idx)
    );

    always_comb
        for (int c = 0; c < NUM_CH; c++)
            acc[c] = start_i[c] & done_o[c] & (byte_len_i[16*c +: 16] != '0);

    assign words = rem_q[gnt_idx][15:2];
    assign rem_n = rem_q[ch] - {9'd0, beats, 2'b00};

    assign arvalid_o = state == ST_RREQ;
    assign araddr_o  = src_q[ch];
    assign arlen_o   = 4'(beats - 5'd1);
    assign arsize_o  = SIZE_4B;
    assign arburst_o = BURST_INCR;
    assign arid_o    = ID_W'(ch);
    assign rready_o  = state == ST_RDATA;
    assign awvalid_o = state == ST_WREQ;
    assign awaddr_o  = dst_q[ch];
    assign awlen_o   = 4'(beats - 5'd1);
    assign awsize_o  = SIZE_4B;
    assign awburst_o = BURST_INCR;
    assign awid_o    = ID_W'(ch);
    assign wvalid_o  = state == ST_WDATA;
    assign wdata_o   = mem[cnt[BW-1:0]];
    assign wstrb_o   = 4'hF;
    assign wlast_o   = wvalid_o && (cnt == beats - 5'd1);
    assign wid_o     = ID_W'(ch);
    assign bready_o  = state == ST_WAIT;

    always_ff @(posedge clk)
        if (state == ST_RDATA && rvalid_i) mem[cnt[BW-1:0]] <= rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ch <= '0;
            last_grant <= CW'(NUM_CH - 1);
            beats <= '0;
            cnt <= '0;
            done_o <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                rem_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (acc[c]) begin
                    src_q[c] <= src_addr_i[32*c +: 32];
                    dst_q[c] <= dst_addr_i[32*c +: 32];
                    rem_q[c] <= byte_len_i[16*c +: 16];
                    done_o[c] <= 1'b0;
                end
            case (state)
                ST_IDLE: if (|gnt) begin
                    ch <= gnt_idx;
                    beats <= (words > 14'(MAX_BURST)) ? 5'(MAX_BURST) : words[4:0];
                    cnt <= '0;
                    state <= ST_RREQ;
                end
                ST_RREQ: if (arready_i) state <= ST_RDATA;
                ST_RDATA: if (rvalid_i) begin
                    cnt <= rlast_i ? 5'd0 : cnt + 5'd1;
                    if (rlast_i) state <= ST_WREQ;
                end
                ST_WREQ: if (awready_i) state <= ST_WDATA;
                ST_WDATA: if (wready_i) begin
                    cnt <= cnt + 5'd1;
                    if (wlast_o) state <= ST_WAIT;
                end
                ST_WAIT: if (bvalid_i) begin
                    src_q[ch] <= src_q[ch] + {25'd0, beats, 2'b00};
                    dst_q[ch] <= dst_q[ch] + {25'd0, beats, 2'b00};
                    rem_q[ch] <= rem_n;
                    if (rem_n == '0 || abort) done_o[ch] <= 1'b1;
                    last_grant <= ch;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMAC_ERR_EN
    logic [NUM_CH-1:0] err_q;
    logic              burst_err;
    logic              unused_ids;
    // A bad R beat marks the burst; it still finishes its write and B before the channel stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            burst_err <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                if (acc[c]) err_q[c] <= 1'b0;
            if (state == ST_IDLE) burst_err <= 1'b0;
            if (state == ST_RDATA && rvalid_i && rresp_i != RESP_OKAY) begin
                burst_err <= 1'b1;
                err_q[ch] <= 1'b1;
            end
            if (state == ST_WAIT && bvalid_i && bresp_i != RESP_OKAY) err_q[ch] <= 1'b1;
        end
    end
    assign err_o = err_q;
    assign abort = burst_err | (bresp_i != RESP_OKAY);
    assign unused_ids = ^{rid_i, bid_i};
`else
    logic unused_resp;
    assign err_o = '0;
    assign abort = 1'b0;
    assign unused_resp = ^{rid_i, bid_i, rresp_i, bresp_i};
`endif
endmodule

// File: tb/tb_dmac_mc_engine.sv
// tb_dmac_mc_engine: directed table plus hand sequences against an AXI3 memory slave model.
module tb_dmac_mc_engine;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NC*32-1:0] src_addr_i, dst_addr_i;
    logic [NC*16-1:0] byte_len_i;
    logic [NC-1:0] start_i, done_o, err_o;
    logic awvalid_o, awready_i, wvalid_o, wready_i, wlast_o, bvalid_i, bready_o;
    logic arvalid_o, arready_i, rvalid_i, rready_o, rlast_i;
    logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i;
    logic [3:0] awlen_o, arlen_o, wstrb_o, awid_o, wid_o, bid_i, arid_o, rid_i;
    logic [2:0] awsize_o, arsize_o;
    logic [1:0] awburst_o, arburst_o, bresp_i, rresp_i;

    dmac_mc_engine #(.NUM_CH(NC), .MAX_BURST(16)) dut (
        .clk(clk), .rst_n(rst_n), .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i),
        .byte_len_i(byte_len_i), .start_i(start_i), .done_o(done_o), .err_o(err_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
        .awsize_o(awsize_o), .awburst_o(awburst_o), .awid_o(awid_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .wlast_o(wlast_o), .wid_o(wid_o), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .bresp_i(bresp_i), .bid_i(bid_i), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arid_o(arid_o), .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .rid_i(rid_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [3:0] len; } req_t;
    typedef struct { int ch; logic [31:0] src; logic [31:0] dst; logic [15:0] len; int nb; logic [3:0] l0; logic [3:0] ll; } vec_t;

    req_t ar_q[$], aw_q[$];
    logic [31:0] mem [16384];
    int total = 0, bad = 0, cyc = 0, b_cnt = 0;
    int rd_left, wr_left;
    logic rd_act, wr_act, b_pend, err_arm;
    logic [31:0] rd_addr, wr_addr;
    logic [3:0] rd_id, wr_id, b_id, err_id;
    logic [1:0] b_resp;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic int mism(input logic [31:0] s, input logic [31:0] d, input int n);
        int m = 0;
        for (int k = 0; k < n; k++)
            if (mem[int'(d[15:2]) + k] !== pat(s + 32'(4 * k))) m++;
        return m;
    endfunction

    task automatic slave_clear();
        rd_act = 0; wr_act = 0; b_pend = 0; rd_left = 0; wr_left = 0;
        arready_i = 0; awready_i = 0; wready_i = 0; rvalid_i = 0; rlast_i = 0;
        bvalid_i = 0; bresp_i = 0; bid_i = 0; rresp_i = 0; rid_i = 0; rdata_i = 0;
    endtask

    // Slave decides at each negedge what handshakes the next posedge will complete.
    initial begin
        slave_clear();
        err_arm = 0; err_id = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                slave_clear();
                continue;
            end
            if (b_pend) begin
                bvalid_i = 1; bid_i = b_id; bresp_i = b_resp;
                if (bready_o) begin b_pend = 0; b_cnt++; end
            end else begin
                bvalid_i = 0; bresp_i = 0;
            end
            wready_i = wr_act && (cyc % 4 != 3);
            if (wready_i && wvalid_o) begin
                chk("wbeat", 32'({wlast_o, wstrb_o, wid_o}), 32'({wr_left == 1, 4'hF, wr_id}));
                mem[wr_addr[15:2]] = wdata_o;
                wr_addr += 4; wr_left--;
                if (wr_left == 0) begin
                    wr_act = 0; b_pend = 1; b_id = wr_id;
                    b_resp = (err_arm && wr_id == err_id) ? 2'b10 : 2'b00;
                    if (err_arm && wr_id == err_id) err_arm = 0;
                end
            end
            awready_i = 0;
            if (!wr_act && !b_pend && awvalid_o) begin
                awready_i = 1;
                chk("awattr", 32'({awsize_o, awburst_o}), 32'({3'b010, 2'b01}));
                aw_q.push_back('{awid_o, awaddr_o, awlen_o});
                wr_act = 1; wr_addr = awaddr_o; wr_left = int'(awlen_o) + 1; wr_id = awid_o;
            end
            if (rd_act) begin
                rvalid_i = (cyc % 3 != 2); rdata_i = mem[rd_addr[15:2]];
                rlast_i = rd_left == 1; rid_i = rd_id; rresp_i = 0;
                if (rvalid_i && rready_o) begin
                    rd_addr += 4; rd_left--;
                    if (rd_left == 0) rd_act = 0;
                end
            end else begin
                rvalid_i = 0; rlast_i = 0;
            end
            arready_i = 0;
            if (!rd_act && arvalid_o) begin
                arready_i = 1;
                chk("overlap", 32'({wr_act, b_pend, arsize_o, arburst_o}), 32'({1'b0, 1'b0, 3'b010, 2'b01}));
                ar_q.push_back('{arid_o, araddr_o, arlen_o});
                rd_act = 1; rd_addr = araddr_o; rd_left = int'(arlen_o) + 1; rd_id = arid_o;
            end
        end
    end

    task automatic set_ch(input int c, input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        src_addr_i[32*c +: 32] = s;
        dst_addr_i[32*c +: 32] = d;
        byte_len_i[16*c +: 16] = l;
    endtask

    task automatic pulse(input logic [NC-1:0] m);
        @(negedge clk);
        start_i = m;
        @(negedge clk);
        start_i = '0;
    endtask

    task automatic wait_done(input logic [NC-1:0] m, input string nm);
        int n = 0;
        while ((done_o & m) != m && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(done_o & m), 32'(m));
    endtask

    task automatic clear_logs();
        ar_q.delete(); aw_q.delete(); b_cnt = 0;
    endtask

    vec_t tv[5];
    logic [3:0] eid[4];
    logic [31:0] eaddr[4];

    initial begin
        tv[0] = '{0, 32'h1000, 32'h2000, 16'd64, 1, 4'd15, 4'd15};
        tv[1] = '{2, 32'h1100, 32'h2400, 16'd20, 1, 4'd4,  4'd4};
        tv[2] = '{1, 32'h1300, 32'h2C00, 16'd4,  1, 4'd0,  4'd0};
        tv[3] = '{0, 32'h1400, 32'h3000, 16'd68, 2, 4'd15, 4'd0};
        tv[4] = '{3, 32'h1200, 32'h2800, 16'd72, 2, 4'd15, 4'd1};
        eid = '{4'd0, 4'd1, 4'd0, 4'd1};
        eaddr = '{32'h1000, 32'h1800, 32'h1040, 32'h1840};
        for (int i = 0; i < 16384; i++) mem[i] = pat(32'(i * 4));
        rst_n = 0; start_i = '0; src_addr_i = '0; dst_addr_i = '0; byte_len_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done_o), 32'hF);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_valid", 32'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 32'h0);
        rst_n = 1;

        for (int i = 0; i < 5; i++) begin
            clear_logs();
            set_ch(tv[i].ch, tv[i].src, tv[i].dst, tv[i].len);
            pulse(NC'(1) << tv[i].ch);
            chk("busy", 32'(done_o[tv[i].ch]), 32'h0);
            wait_done(NC'(1) << tv[i].ch, "done");
            chk("b_before_done", 32'(b_cnt), 32'(tv[i].nb));
            chk("ar_cnt", 32'(ar_q.size()), 32'(tv[i].nb));
            chk("arlen0", 32'(ar_q[0].len), 32'(tv[i].l0));
            chk("araddr0", ar_q[0].addr, tv[i].src);
            chk("arid", 32'(ar_q[0].id), 32'(tv[i].ch));
            chk("awlen_last", 32'(aw_q[aw_q.size() - 1].len), 32'(tv[i].ll));
            chk("awaddr_last", aw_q[aw_q.size() - 1].addr, tv[i].dst + 32'(64 * (tv[i].nb - 1)));
            chk("data", 32'(mism(tv[i].src, tv[i].dst, int'(tv[i].len) / 4)), 32'h0);
        end

        clear_logs();
        set_ch(0, 32'h1000, 32'h2000, 16'd128);
        set_ch(1, 32'h1800, 32'h2800, 16'd128);
        pulse(4'b0011);
        wait_done(4'b0011, "dual_done");
        chk("dual_ar_cnt", 32'(ar_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("dual_arid", 32'(ar_q[k].id), 32'(eid[k]));
            chk("dual_araddr", ar_q[k].addr, eaddr[k]);
        end
        chk("dual_data0", 32'(mism(32'h1000, 32'h2000, 32)), 32'h0);
        chk("dual_data1", 32'(mism(32'h1800, 32'h2800, 32)), 32'h0);

        clear_logs();
        set_ch(0, 32'h1000, 32'h3400, 16'd64);
        pulse(4'b0001);
        repeat (3) @(negedge clk);
        set_ch(0, 32'h1500, 32'h3500, 16'd128);
        pulse(4'b0001);
        wait_done(4'b0001, "busy_done");
        repeat (3) @(negedge clk);
        chk("busy_ignored", 32'(ar_q.size()), 32'd1);
        chk("busy_data", 32'(mism(32'h1000, 32'h3400, 16)), 32'h0);
        clear_logs();
        set_ch(2, 32'h1000, 32'h3600, 16'd0);
        pulse(4'b0100);
        chk("zero_len_done", 32'(done_o[2]), 32'h1);
        repeat (5) @(negedge clk);
        chk("zero_len_noar", 32'(ar_q.size()) | 32'(done_o[2] != 1'b1), 32'h0);

        clear_logs();
        set_ch(1, 32'h1000, 32'h3A00, 16'd64);
        pulse(4'b0010);
        begin
            int n = 0;
            while (!wvalid_o && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("reach_wdata", 32'(wvalid_o), 32'h1);
        end
        rst_n = 0;
        #1;
        chk("mid_rst_valid", 32'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 32'h0);
        chk("mid_rst_done", 32'(done_o), 32'hF);
        repeat (3) @(negedge clk);
        rst_n = 1;
        clear_logs();
        set_ch(2, 32'h1600, 32'h3B00, 16'd32);
        pulse(4'b0100);
        wait_done(4'b0100, "post_rst_done");
        chk("post_rst_ar", 32'(ar_q.size()) | (32'(ar_q[0].len) << 8), 32'h0701);
        chk("post_rst_data", 32'(mism(32'h1600, 32'h3B00, 8)), 32'h0);

        clear_logs();
        err_arm = 1; err_id = 4'd1;
        set_ch(0, 32'h1800, 32'h3800, 16'd128);
        set_ch(1, 32'h1900, 32'h3C00, 16'd128);
        pulse(4'b0011);
        wait_done(4'b0011, "err_done");
        chk("err_ch0_data", 32'(mism(32'h1800, 32'h3800, 32)), 32'h0);
`ifdef DMAC_ERR_EN
        chk("err_flag", 32'(err_o), 32'h2);
        chk("err_ar_cnt", 32'(ar_q.size()), 32'd3);
`else
        chk("err_flag", 32'(err_o), 32'h0);
        chk("err_ar_cnt", 32'(ar_q.size()), 32'd4);
        chk("err_ch1_data", 32'(mism(32'h1900, 32'h3C00, 32)), 32'h0);
`endif
        set_ch(1, 32'h1000, 32'h3E00, 16'd4);
        pulse(4'b0010);
        chk("err_clear", 32'(err_o), 32'h0);
        wait_done(4'b0010, "err_restart_done");
        chk("err_restart_data", 32'(mism(32'h1000, 32'h3E00, 1)), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
